change_dispenser: RTL
=====================

Name: change_dispenser

Overview:
Return path of the vending credit datapath. On a refund request it snapshots the current credit and pays it out greedily as quarters, dimes and nickels, one coin per hopper handshake. It emits a signed per-coin credit adjustment that is summed into the credit register alongside the purchase debits. It is the refund side of the purchase block: the purchase block debits credit for goods, and this block debits it for returned coins.

Parameters:
QUARTER, 25, value of coin slot 2
DIME, 10, value of coin slot 1
NICKEL, 5, value of coin slot 0
TIMEOUT, 255, cycles to wait for CoinTaken before declaring a jam (8-bit counter)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
Money  in  7  current credit, unsigned cents
Refund  in  1  refund request, sampled only in IDLE
CoinTaken  in  1  hopper acknowledge; consumes the presented coin
Coin  out  3  one-hot coin select {Q,D,N}; 0 when no coin is presented
CoinValid  out  1  a coin is presented
C  out  7  signed credit adjustment (two's complement), nonzero only on the handshake cycle
Busy  out  1  refund in progress; the purchase path must gate Buy with it
Done  out  1  one-cycle pulse at refund completion
Jam  out  1  sticky; set on timeout, cleared by next accepted Refund or reset
Stranded  out  3  residue (0-4) left unpaid by the last refund

Behaviour:
- Reset (Reset=0, async): state=IDLE, Remaining=0, timer=0, Coin=0, CoinValid=0, C=0, Busy=0, Done=0, Jam=0, Stranded=0.
- States: IDLE, DISPENSE, DONE.
- IDLE:
  - On Refund=1, latch Remaining<=Money, clear Jam and Stranded, go to DISPENSE.
  - Busy rises on the following cycle.
- DISPENSE:
  - Busy=1.
  - Coin is the combinational greedy choice from Remaining: Q if Remaining>=QUARTER, else D if >=DIME, else N if >=NICKEL, else 0.
  - CoinValid=|Coin.
  - The first coin is valid the cycle after Refund is sampled.
- Handshake (CoinValid & CoinTaken, same cycle):
  - C = -value(Coin), combinational.
  - Remaining <= Remaining - value on the next edge.
  - Timer resets to 0.
  - The next coin is presented the cycle after. CoinTaken may stay high, giving one coin per cycle.
- CoinTaken while CoinValid=0: ignored, C=0.
- Remaining < NICKEL in DISPENSE: Stranded<=Remaining[2:0], go to DONE. Money=0 therefore yields no coins and DONE one cycle after DISPENSE entry.
- Timer:
  - Increments each DISPENSE cycle with CoinValid & !CoinTaken.
  - When it reaches TIMEOUT: Jam<=1, Stranded<=0, go to DONE.
  - Remaining is abandoned; the credit register keeps the unpaid amount.
- DONE: Done=1 for exactly one cycle, Busy=1, go to IDLE.
- Refund asserted outside IDLE: ignored, no queuing.
- Money changes after the snapshot: ignored until the next refund.
- Arithmetic:
  - Remaining is 7-bit unsigned.
  - Subtraction never underflows because greedy selection guarantees value<=Remaining.
  - C is the 7-bit two's complement of the value: Q=7'h67, D=7'h76, N=7'h7B.
- Reset mid-DISPENSE: immediate return to the reset values. A coin whose handshake had not completed is never debited.

Decomposition:
- Package vend_pkg:
  - coin value constants
  - one-hot coin encoding (COIN_N=3'b001, COIN_D=3'b010, COIN_Q=3'b100)
  - state enum {IDLE, DISPENSE, DONE}
  - 7-bit credit typedef shared with the purchase path
- Sub-module coin_select:
  - Purely combinational.
  - Maps Remaining to one-hot Coin plus the negated adjustment value.
  - Reusable for the purchase-side cost checks.

Test Plan:
- Money=45, Refund pulse, CoinTaken held 1 -> Coin Q,D,D on three consecutive cycles; C=-25,-10,-10; Done one cycle later; Stranded=0; Jam=0.
- Money=0, Refund -> no CoinValid; Done pulses two cycles after Refund; C stays 0.
- Money=7, Refund, CoinTaken=1 -> single N, C=-5, Stranded=2, Done.
- Money=30, CoinTaken held 0 -> Q presented stably for TIMEOUT cycles, then Jam=1 and Done pulse with no C activity. A later Refund clears Jam.
- Money=60, Refund, second Refund while Busy, CoinTaken toggling 1/0 -> only Q,Q,D paid (C sum -60), second request ignored.
- Money=40, Reset low during the D presentation before CoinTaken -> all outputs at reset values asynchronously, only the already-taken Q debited (-25), IDLE after release.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the vending credit datapath.
// Contents:
//   credit_t              - 7-bit unsigned credit in cents; also used by the purchase path
//   *_CENTS               - default coin values
//   COIN_*                - one-hot coin select {Q,D,N}
//   TIMEOUT_CYCLES        - default hopper acknowledge timeout
//   state_e               - refund FSM state encoding
//   negate()              - 7-bit two's complement of a credit value
package vend_pkg;

  typedef logic [6:0] credit_t;

  localparam credit_t QUARTER_CENTS = 7'd25;
  localparam credit_t DIME_CENTS    = 7'd10;
  localparam credit_t NICKEL_CENTS  = 7'd5;

  localparam logic [2:0] COIN_NONE = 3'b000;
  localparam logic [2:0] COIN_N    = 3'b001;
  localparam logic [2:0] COIN_D    = 3'b010;
  localparam logic [2:0] COIN_Q    = 3'b100;

  localparam logic [7:0] TIMEOUT_CYCLES = 8'd255;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    DONE     = 2'd2
  } state_e;

  // Credit adjustments are summed into the credit register, so a debit is
  // carried as the modulo-128 negative of the coin value.
  function automatic credit_t negate(input credit_t v);
    return 7'd0 - v;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Bus between the credit datapath / coin hopper and the change dispenser.
// Signals:
//   money      credit snapshot source (cents)
//   refund     refund request
//   coin_taken hopper acknowledge for the presented coin
//   coin       one-hot coin presented {Q,D,N}
//   coin_valid a coin is presented
//   c          signed per-coin credit adjustment
//   busy       refund in progress (gates purchases)
//   done       one-cycle completion pulse
//   jam        sticky hopper timeout flag
//   stranded   residue left unpaid by the last refund
// Modports: slave = dispenser side, master = datapath/hopper side.
interface change_dispenser_if;
  import vend_pkg::*;

  credit_t    money;
  logic       refund;
  logic       coin_taken;
  logic [2:0] coin;
  logic       coin_valid;
  credit_t    c;
  logic       busy;
  logic       done;
  logic       jam;
  logic [2:0] stranded;

  modport slave (
    input  money, refund, coin_taken,
    output coin, coin_valid, c, busy, done, jam, stranded
  );

  modport master (
    output money, refund, coin_taken,
    input  coin, coin_valid, c, busy, done, jam, stranded
  );

endinterface

// File: rtl/coin_select.sv
// Greedy coin selector (purely combinational).
// Ports:
//   remaining in  credit still owed
//   coin      out one-hot largest coin not exceeding remaining, 0 if none fits
//   adjust    out negated value of the selected coin (0 when none)
module coin_select
  import vend_pkg::*;
#(
  parameter credit_t QUARTER = QUARTER_CENTS,
  parameter credit_t DIME    = DIME_CENTS,
  parameter credit_t NICKEL  = NICKEL_CENTS
) (
  input  credit_t    remaining,
  output logic [2:0] coin,
  output credit_t    adjust
);

  always_comb begin
    coin   = COIN_NONE;
    adjust = '0;
    if (remaining >= QUARTER) begin
      coin   = COIN_Q;
      adjust = negate(QUARTER);
    end else if (remaining >= DIME) begin
      coin   = COIN_D;
      adjust = negate(DIME);
    end else if (remaining >= NICKEL) begin
      coin   = COIN_N;
      adjust = negate(NICKEL);
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Refund side of the vending credit datapath. On a refund request the current
// credit is snapshotted and paid out greedily, one coin per hopper handshake,
// with a signed adjustment emitted on each handshake for the credit register.
// Ports:
//   clk   in  system clock, rising edge
//   reset in  asynchronous active-low reset
//   bus   slave side of change_dispenser_if (see that file for signals)
module change_dispenser
  import vend_pkg::*;
#(
  parameter credit_t    QUARTER = QUARTER_CENTS,
  parameter credit_t    DIME    = DIME_CENTS,
  parameter credit_t    NICKEL  = NICKEL_CENTS,
  parameter logic [7:0] TIMEOUT = TIMEOUT_CYCLES
) (
  input logic              clk,
  input logic              reset,
  change_dispenser_if.slave bus
);

  localparam logic [1:0] S_IDLE     = IDLE;
  localparam logic [1:0] S_DISPENSE = DISPENSE;
  localparam logic [1:0] S_DONE     = DONE;

  logic [1:0] state_reg;
  credit_t    remaining_reg;
  logic [7:0] timer_reg;
  logic       jam_reg;
  logic [2:0] stranded_reg;

  logic [2:0] sel_coin;
  credit_t    sel_adjust;
  credit_t    remaining_after;
  logic       in_dispense;
  logic       handshake;

  coin_select #(
    .QUARTER(QUARTER),
    .DIME   (DIME),
    .NICKEL (NICKEL)
  ) u_select (
    .remaining(remaining_reg),
    .coin     (sel_coin),
    .adjust   (sel_adjust)
  );

  assign in_dispense     = (state_reg == S_DISPENSE);
  assign bus.coin        = in_dispense ? sel_coin : COIN_NONE;
  assign bus.coin_valid  = |bus.coin;
  assign handshake       = bus.coin_valid & bus.coin_taken;
  assign bus.c           = handshake ? sel_adjust : '0;
  // Adding the negated value is the subtraction; greedy choice keeps it >= 0.
  assign remaining_after = remaining_reg + sel_adjust;
  assign bus.busy        = (state_reg != S_IDLE);
  assign bus.done        = (state_reg == S_DONE);
  assign bus.jam         = jam_reg;
  assign bus.stranded    = stranded_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= S_IDLE;
      remaining_reg <= '0;
      timer_reg     <= '0;
      jam_reg       <= 1'b0;
      stranded_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.refund) begin
            remaining_reg <= bus.money;
            timer_reg     <= '0;
            jam_reg       <= 1'b0;
            stranded_reg  <= '0;
            state_reg     <= S_DISPENSE;
          end
        end

        S_DISPENSE: begin
          if (!bus.coin_valid) begin
            // Less than the smallest coin owed on entry (e.g. zero credit).
            stranded_reg <= remaining_reg[2:0];
            state_reg    <= S_DONE;
          end else if (bus.coin_taken) begin
            remaining_reg <= remaining_after;
            timer_reg     <= '0;
            // Finish straight off the last payable coin so Done follows it
            // immediately instead of after an idle presentation slot.
            if (remaining_after < NICKEL) begin
              stranded_reg <= remaining_after[2:0];
              state_reg    <= S_DONE;
            end
          end else begin
            timer_reg <= timer_reg + 8'd1;
            if (timer_reg == TIMEOUT - 8'd1) begin
              // Abandon the rest; the credit register still holds it.
              jam_reg      <= 1'b1;
              stranded_reg <= '0;
              timer_reg    <= '0;
              state_reg    <= S_DONE;
            end
          end
        end

        S_DONE: state_reg <= S_IDLE;

        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule
